seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment driver: hex decode, guarded anode scan and
// frame-synchronous double-buffered display data.
module seg7_scan #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1_000,
    parameter int unsigned GUARD   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    input  logic        lz_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

    typedef enum logic {
        OFF,
        SCAN
    } state_t;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dots;
        logic [7:0]  dark;
    } frame_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    frame_t        disp;
    frame_t        pend;
    frame_t        live;
    logic          pend_flag;

    logic          running;
    logic          frame_end;
    logic          lit;
    logic          zero_run;
    logic [7:0]    lz_dark;
    logic [3:0]    nibble;
    logic          digit_dark;
    logic [6:0]    glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        logic [6:0] g;
        case (h)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        live.digits = data;
        live.dots   = dp_mask;
        live.dark   = blank_mask;
        running     = (state == SCAN) && enable;
        frame_end   = running && (cnt == CNT_LAST) && (idx == 3'd7);
        lit         = running && (cnt >= GUARD_END);
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int unsigned i = 7; i >= 1; i--) begin
            zero_run   = zero_run && (disp.digits[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run;
        end
    end

    always_comb begin
        nibble     = disp.digits[{idx, 2'b00} +: 4];
        digit_dark = disp.dark[idx] || (lz_en && lz_dark[idx]);
        glyph      = digit_dark ? 7'h7F : hex_glyph(nibble);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_flag  <= 1'b0;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    cnt <= '0;
                    idx <= '0;
                    if (enable) state <= SCAN;
                end
                SCAN: begin
                    if (!enable) begin
                        state <= OFF;
                        cnt   <= '0;
                        idx   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        idx <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= OFF;
            endcase

            // A load coinciding with the frame boundary bypasses the pending buffer.
            if (frame_end) begin
                pend_flag <= 1'b0;
                if (load) begin
                    disp <= live;
                end else if (pend_flag) begin
                    disp <= pend;
                end
            end else if (load) begin
                pend      <= live;
                pend_flag <= 1'b1;
            end

            frame_done <= frame_end;

            if (lit) begin
                an  <= ~(8'd1 << idx);
                seg <= glyph;
                dp  <= ~disp.dots[idx];
            end else begin
                an  <= '1;
                seg <= '1;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at DIV=8, GUARD=2: a cycle model queues the
// expected registered outputs and each scenario task compares them as they emerge.
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int GUARD = 2;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  blank_mask;
    logic        lz_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       seg_care;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit          m_scan;
    int          m_cnt, m_idx, m_frame;
    logic [31:0] m_data, p_data;
    logic [7:0]  m_dpm, m_bm, p_dpm, p_bm;
    bit          m_pf;
    int          last_idx, last_cnt, last_frame;

    seg7_scan #(.CLK_HZ(8), .SCAN_HZ(1), .GUARD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic model_reset();
        m_scan = 0; m_cnt = 0; m_idx = 0; m_frame = 0;
        m_data = '0; m_dpm = '0; m_bm = '0;
        p_data = '0; p_dpm = '0; p_bm = '0; m_pf = 0;
        exp_q.delete();
    endtask

    // Queue the output expected after the next edge, advance the model, then clock.
    task automatic cycle();
        exp_t e;
        bit   bnd;
        bit   dark;
        bnd = m_scan && enable && m_idx == 7 && m_cnt == DIV - 1;
        e.fd = bnd;
        if (!m_scan || !enable) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.seg_care = 1'b1;
        end else if (m_cnt < GUARD) begin
            e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.seg_care = 1'b0;
        end else begin
            dark = m_bm[m_idx] || (lz_en && m_idx != 0 && (m_data >> (4*m_idx)) == 32'd0);
            e.an = ~(8'd1 << m_idx);
            e.seg = dark ? 7'h7F : hex7(m_data[4*m_idx +: 4]);
            e.dp = ~m_dpm[m_idx];
            e.seg_care = 1'b1;
        end
        exp_q.push_back(e);
        last_idx = m_idx; last_cnt = m_cnt; last_frame = m_frame;
        if (bnd) begin
            if (load) begin
                m_data = data; m_dpm = dp_mask; m_bm = blank_mask;
            end else if (m_pf) begin
                m_data = p_data; m_dpm = p_dpm; m_bm = p_bm;
            end
            m_pf = 0;
            m_frame++;
        end else if (load) begin
            p_data = data; p_dpm = dp_mask; p_bm = blank_mask; m_pf = 1;
        end
        if (!m_scan) begin
            m_scan = enable; m_cnt = 0; m_idx = 0;
        end else if (!enable) begin
            m_scan = 0; m_cnt = 0; m_idx = 0;
        end else if (m_cnt == DIV - 1) begin
            m_cnt = 0; m_idx = (m_idx + 1) % 8;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h, expected ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h, expected 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b, expected 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, expected 0", frame_done); end
        @(posedge clk);
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_held_an: got %h, expected ff", an); end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        exp_t       e;
        logic [6:0] d0 = 'x;
        logic [6:0] d1 = 'x;
        int         guard_n = 0;
        data = 32'h0000_00A1; dp_mask = '0; blank_mask = '0; lz_en = 1'b0; load = 1'b1;
        for (int n = 0; n < 130; n++) begin
            if (n == 1) begin load = 1'b0; enable = 1'b1; end
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL basic_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (last_frame == 1) begin
                if (an === 8'hFF) guard_n++;
                if (last_idx == 0 && last_cnt == 4) d0 = seg;
                if (last_idx == 1 && last_cnt == 4) d1 = seg;
            end
        end
        checks++; if (d0 !== 7'b1111001) begin errors++; $display("FAIL basic_digit0: got %b, expected 1111001", d0); end
        checks++; if (d1 !== 7'b0001000) begin errors++; $display("FAIL basic_digit1: got %b, expected 0001000", d1); end
        checks++; if (guard_n != 16) begin errors++; $display("FAIL basic_guard_cycles: got %0d, expected 16", guard_n); end
    endtask

    task automatic test_lz();
        exp_t       e;
        int         hi_n = 0, hi_bad = 0, fd_n = 0, t1 = 0, t2 = 0;
        logic [6:0] d0 = 'x;
        logic [6:0] d1 = 'x;
        lz_en = 1'b1;
        for (int n = 0; n < 128; n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL lz_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (frame_done === 1'b1) begin
                fd_n++;
                if (fd_n == 1) t1 = n; else t2 = n;
            end
            if (last_idx >= 2 && last_cnt >= GUARD) begin
                hi_n++;
                if (seg !== 7'h7F) hi_bad++;
            end
            if (last_idx == 0 && last_cnt == 5) d0 = seg;
            if (last_idx == 1 && last_cnt == 5) d1 = seg;
        end
        lz_en = 1'b0;
        checks++; if (hi_n != 72 || hi_bad != 0) begin errors++; $display("FAIL lz_high_dark: got %0d lit of %0d not 7f, expected 72 lit all 7f", hi_bad, hi_n); end
        checks++; if (d0 !== 7'b1111001) begin errors++; $display("FAIL lz_digit0: got %b, expected 1111001", d0); end
        checks++; if (d1 !== 7'b0001000) begin errors++; $display("FAIL lz_digit1: got %b, expected 0001000", d1); end
        checks++; if (fd_n != 2 || t2 - t1 != 64) begin errors++; $display("FAIL lz_frame_done: got %0d pulses spaced %0d, expected 2 spaced 64", fd_n, t2 - t1); end
    endtask

    task automatic test_mid_frame_load();
        exp_t       e;
        int         f0;
        logic [6:0] old_s = 'x;
        logic [6:0] new_s = 'x;
        for (int n = 0; n < 200 && !(m_idx == 2 && m_cnt == 5); n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL midload_align t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
        f0 = m_frame;
        data = 32'h8888_8888; load = 1'b1;
        for (int n = 0; n < 111; n++) begin
            cycle();
            if (n == 0) begin load = 1'b0; data = 32'h0000_5555; end
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL midload_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (last_frame == f0 && last_idx == 5 && last_cnt == 4) old_s = seg;
            if (last_frame == f0 + 1 && last_idx == 0 && last_cnt == 4) new_s = seg;
        end
        checks++; if (old_s !== 7'b1000000) begin errors++; $display("FAIL midload_old_persists: got %b, expected 1000000", old_s); end
        checks++; if (new_s !== 7'b0000000) begin errors++; $display("FAIL midload_new_digit0: got %b, expected 0000000", new_s); end
    endtask

    task automatic test_boundary_load();
        exp_t e;
        int   f0, lit_n = 0, bad = 0;
        for (int n = 0; n < 200 && !(m_idx == 7 && m_cnt == DIV - 1); n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL bndload_align t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
        f0 = m_frame;
        data = 32'hFFFF_FFFF; load = 1'b1;
        for (int n = 0; n < 71; n++) begin
            cycle();
            if (n == 0) begin load = 1'b0; data = '0; end
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL bndload_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (last_frame == f0 + 1 && last_cnt >= GUARD) begin
                lit_n++;
                if (seg !== 7'b0001110) bad++;
            end
        end
        checks++; if (lit_n != 48 || bad != 0) begin errors++; $display("FAIL bndload_all_f: got %0d of %0d lit not 0001110, expected 48 lit all 0001110", bad, lit_n); end
    endtask

    task automatic test_dp_blank();
        exp_t       e;
        int         f0;
        logic [6:0] s1 = 'x, s2 = 'x, s3 = 'x;
        logic       p1 = 1'bx, p2 = 1'bx, p3 = 1'bx;
        data = 32'h7654_3210; dp_mask = 8'b0000_0110; blank_mask = 8'b0000_0010; load = 1'b1;
        f0 = m_frame;
        for (int n = 0; n < 140; n++) begin
            cycle();
            if (n == 0) begin load = 1'b0; data = '0; dp_mask = '0; blank_mask = '0; end
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL dpblank_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (last_frame == f0 + 1 && last_cnt == 4) begin
                if (last_idx == 1) begin s1 = seg; p1 = dp; end
                if (last_idx == 2) begin s2 = seg; p2 = dp; end
                if (last_idx == 3) begin s3 = seg; p3 = dp; end
            end
        end
        checks++; if (s1 !== 7'h7F || p1 !== 1'b0) begin errors++; $display("FAIL dpblank_digit1: got seg=%b dp=%b, expected seg=1111111 dp=0", s1, p1); end
        checks++; if (s2 !== 7'b0100100 || p2 !== 1'b0) begin errors++; $display("FAIL dpblank_digit2: got seg=%b dp=%b, expected seg=0100100 dp=0", s2, p2); end
        checks++; if (s3 !== 7'b0110000 || p3 !== 1'b1) begin errors++; $display("FAIL dpblank_digit3: got seg=%b dp=%b, expected seg=0110000 dp=1", s3, p3); end
    endtask

    task automatic test_disable();
        exp_t       e;
        logic [7:0] a3 = 'x, a4 = 'x;
        for (int n = 0; n < 200 && !(m_idx == 3 && m_cnt == 4); n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL disable_align t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
        enable = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (n == 6) enable = 1'b1;
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL disable_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (n == 0) begin
                checks++;
                if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL disable_next_off: got an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an, seg, dp);
                end
            end
            if (n == 8) a3 = an;
            if (n == 9) a4 = an;
        end
        checks++; if (a3 !== 8'hFF) begin errors++; $display("FAIL reenable_guard: got an=%h, expected ff", a3); end
        checks++; if (a4 !== 8'hFE) begin errors++; $display("FAIL reenable_digit0: got an=%h, expected fe", a4); end
    endtask

    task automatic test_mid_reset();
        exp_t       e;
        logic [6:0] s3 = 'x;
        logic       p3 = 1'bx;
        for (int n = 0; n < 200 && !(m_idx == 2 && m_cnt == 4); n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL rstmid_align t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
        data = 32'h9999_9999; dp_mask = '1; load = 1'b1;
        cycle();
        load = 1'b0;
        e = exp_q.pop_front();
        checks++; if (an !== 8'hFB) begin errors++; $display("FAIL rstmid_lit_before: got an=%h, expected fb", an); end
        #3 rst = 1'b0;
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL rstmid_an: got %h, expected ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rstmid_seg: got %h, expected 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rstmid_dp: got %b, expected 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_fd: got %b, expected 0", frame_done); end
        @(posedge clk);
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL rstmid_held_an: got %h, expected ff", an); end
        model_reset();
        rst = 1'b1;
        for (int n = 0; n < 140; n++) begin
            cycle();
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an || dp !== e.dp || frame_done !== e.fd || (e.seg_care && seg !== e.seg)) begin
                errors++;
                $display("FAIL rstmid_cycle t=%0t: an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            if (last_frame == 1 && last_idx == 3 && last_cnt == 4) begin s3 = seg; p3 = dp; end
        end
        checks++; if (s3 !== 7'b1000000 || p3 !== 1'b1) begin errors++; $display("FAIL rstmid_data_cleared: got seg=%b dp=%b, expected seg=1000000 dp=1", s3, p3); end
    endtask

    initial begin
        enable = 1'b0; load = 1'b0; data = '0; dp_mask = '0; blank_mask = '0; lz_en = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_lz();
        test_mid_frame_load();
        test_boundary_load();
        test_dp_blank();
        test_disable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
